wb_arbiter_n: RTL and testbench

Parametrised N-master Wishbone pipelined arbiter, successor to the two-input fixed-priority arbiter. Sits between several bus masters (CPU fetch, data, DMA, cache refill) and one shared `if_wb` slave path. Grants are registered and held for a whole bus cycle (`cyc` high). Selection is round-robin or fixed-priority by compile option.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/if_wb.sv | 21 ++
 rtl/wb_arbiter_n_picker.sv | 57 +++++
 rtl/wb_arbiter_n.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter_n.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int NUM_MASTERS_MAX = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [3:0] onehot_to_idx(input logic [NUM_MASTERS_MAX-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS_MAX; i++) begin
            if (oh[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/if_wb.sv
// Wishbone pipelined bus bundle: 32-bit address/data, 4-bit byte select.
// Handshake: a transfer request is taken on a rising edge where cyc=1, stb=1
// and stall=0 (stb is "valid", ~stall is "ready"); a request held while stall=1
// must keep its stb and payload stable. ack returns one completion per request.
// dat_w carries master-to-slave write data, dat_r slave-to-master read data.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, sel, adr, dat_w,
                    input  ack, stall, dat_r);
    modport slave  (input  cyc, stb, we, sel, adr, dat_w,
                    output ack, stall, dat_r);
endinterface

// File: rtl/wb_arbiter_n_picker.sv
// Combinational winner picker for the arbiter.
// Build option WB_ARB_RR_EN: defined -> round-robin search starting at start_i
// and wrapping; undefined -> fixed priority, lowest eligible index wins.
module arb_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int OWN_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [OWN_W-1:0]       start_i,
    input  logic [NUM_MASTERS-1:0] excl_i,
    output logic [NUM_MASTERS-1:0] win_o,
    output logic                   valid_o
);

    logic [NUM_MASTERS-1:0] elig;
    assign elig = req_i & ~excl_i;

`ifdef WB_ARB_RR_EN
    // Round-robin: walk positions start_i, start_i+1, ... modulo NUM_MASTERS.
    always_comb begin
        int pos;
        win_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            pos = int'(start_i) + k;
            if (pos >= NUM_MASTERS) begin
                pos = pos - NUM_MASTERS;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!valid_o && (j == pos) && elig[j]) begin
                    win_o[j] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end
`else
    // Fixed priority: the lowest eligible index wins; start_i has no effect.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!valid_o && elig[j]) begin
                win_o[j] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

    logic unused_start;
    assign unused_start = ^start_i;
`endif

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master Wishbone pipelined arbiter with registered, cycle-long grants.
// Build option WB_ARB_RR_EN selects round-robin; otherwise fixed priority.
// Note: rst_i is active-low despite its name.
module wb_arbiter_n
    import wb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int OWN_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    if_wb.slave                    in [NUM_MASTERS],
    if_wb.master                   out,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [OWN_W-1:0]       owner_o
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [OWN_W-1:0]       owner_q, owner_d;

    logic [NUM_MASTERS-1:0] cyc_v, stb_v, we_v;
    logic [3:0]             sel_a [NUM_MASTERS];
    logic [31:0]            adr_a [NUM_MASTERS];
    logic [31:0]            dat_a [NUM_MASTERS];

    // Flatten the master ports and route the return path: only the owner
    // sees ack/stall from downstream, everybody else is stalled.
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
        assign cyc_v[g]    = in[g].cyc;
        assign stb_v[g]    = in[g].stb;
        assign we_v[g]     = in[g].we;
        assign sel_a[g]    = in[g].sel;
        assign adr_a[g]    = in[g].adr;
        assign dat_a[g]    = in[g].dat_w;
        assign in[g].ack   = gnt_q[g] & out.ack;
        assign in[g].stall = ~gnt_q[g] | out.stall;
        assign in[g].dat_r = out.dat_r;
    end

    // Arbitration inputs: the releasing owner is excluded from its own
    // release-cycle pick, and round-robin search begins after the last owner.
    logic                   owner_cyc;
    logic [NUM_MASTERS-1:0] excl;
    logic [OWN_W-1:0]       start_idx;
    logic [NUM_MASTERS-1:0] pick_win;
    logic                   pick_valid;
    logic [NUM_MASTERS_MAX-1:0] pick_ext;
    logic [3:0]             pick_full;
    logic [OWN_W-1:0]       pick_idx;

    assign owner_cyc = |(gnt_q & cyc_v);
    assign excl      = (state_q == ARB_BUSY) ? gnt_q : '0;
    assign start_idx = (owner_q == OWN_W'(NUM_MASTERS - 1)) ? '0 : owner_q + OWN_W'(1);

    arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .OWN_W       (OWN_W)
    ) u_picker (
        .req_i   (cyc_v),
        .start_i (start_idx),
        .excl_i  (excl),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    // Widen the one-hot winner to the package helper's width and take its index.
    always_comb begin
        pick_ext                  = '0;
        pick_ext[NUM_MASTERS-1:0] = pick_win;
        pick_full                 = onehot_to_idx(pick_ext);
        pick_idx                  = pick_full[OWN_W-1:0];
    end

    // Next-state: grab on any request when idle; hold while the owner keeps
    // cyc; on release hand over directly or fall back to idle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    gnt_d   = pick_win;
                    owner_d = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (!owner_cyc) begin
                    if (pick_valid) begin
                        gnt_d   = pick_win;
                        owner_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and owner registers; reset drops any bus cycle at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            owner_q <= OWN_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
        end
    end

    // Forward the granted master's request; all zero when nobody is granted.
    always_comb begin
        out.cyc   = 1'b0;
        out.stb   = 1'b0;
        out.we    = 1'b0;
        out.sel   = '0;
        out.adr   = '0;
        out.dat_w = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (gnt_q[j]) begin
                out.cyc   = cyc_v[j];
                out.stb   = stb_v[j];
                out.we    = we_v[j];
                out.sel   = sel_a[j];
                out.adr   = adr_a[j];
                out.dat_w = dat_a[j];
            end
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Self-checking bench for wb_arbiter_n (4 masters), both arbitration modes.
module tb_wb_arbiter_n;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    logic [N-1:0] m_cyc, m_stb, m_we, m_ack, m_stall;
    logic [3:0]   m_sel [N];
    logic [31:0]  m_adr [N];
    logic [31:0]  m_dat [N];
    logic [31:0]  m_dr  [N];
    logic         s_ack, s_stall;
    logic [31:0]  s_dr;
    logic         o_cyc, o_stb, o_we;
    logic [3:0]   o_sel;
    logic [31:0]  o_adr, o_dat;
    logic [N-1:0] gnt;
    logic [1:0]   owner;

    if_wb m_if [N] ();
    if_wb s_if ();

    for (genvar g = 0; g < N; g++) begin : g_m
        assign m_if[g].cyc   = m_cyc[g];
        assign m_if[g].stb   = m_stb[g];
        assign m_if[g].we    = m_we[g];
        assign m_if[g].sel   = m_sel[g];
        assign m_if[g].adr   = m_adr[g];
        assign m_if[g].dat_w = m_dat[g];
        assign m_ack[g]      = m_if[g].ack;
        assign m_stall[g]    = m_if[g].stall;
        assign m_dr[g]       = m_if[g].dat_r;
    end

    assign s_if.ack   = s_ack;
    assign s_if.stall = s_stall;
    assign s_if.dat_r = s_dr;
    assign o_cyc      = s_if.cyc;
    assign o_stb      = s_if.stb;
    assign o_we       = s_if.we;
    assign o_sel      = s_if.sel;
    assign o_adr      = s_if.adr;
    assign o_dat      = s_if.dat_w;

    wb_arbiter_n #(.NUM_MASTERS(N)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .in      (m_if),
        .out     (s_if),
        .gnt_o   (gnt),
        .owner_o (owner)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mdl_owner: granted master or -1 when idle; mdl_last: most recent owner.
    int mdl_owner;
    int mdl_last;

    function automatic int pick(input logic [N-1:0] req, input int excl);
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (mdl_last + k) % N;
            if (req[c] && c != excl) return c;
        end
`else
        for (int c = 0; c < N; c++) begin
            if (req[c] && c != excl) return c;
        end
`endif
        return -1;
    endfunction

    task automatic check_model(input string tag);
        logic [N-1:0] e_gnt, e_ack, e_stall;
        logic [6:0]   e_ctl;
        logic [31:0]  e_adr, e_dat;
        e_gnt = '0; e_ack = '0; e_stall = '1; e_ctl = '0; e_adr = '0; e_dat = '0;
        if (mdl_owner >= 0) begin
            e_gnt[mdl_owner]   = 1'b1;
            e_ack[mdl_owner]   = s_ack;
            e_stall[mdl_owner] = s_stall;
            e_ctl = {m_cyc[mdl_owner], m_stb[mdl_owner], m_we[mdl_owner], m_sel[mdl_owner]};
            e_adr = m_adr[mdl_owner];
            e_dat = m_dat[mdl_owner];
        end
        check({tag, ":gnt"},    32'(gnt), 32'(e_gnt));
        check({tag, ":owner"},  32'(owner), 32'(mdl_last));
        check({tag, ":out_ctl"}, 32'({o_cyc, o_stb, o_we, o_sel}), 32'(e_ctl));
        check({tag, ":out_adr"}, o_adr, e_adr);
        check({tag, ":out_dat"}, o_dat, e_dat);
        check({tag, ":ack"},    32'(m_ack), 32'(e_ack));
        check({tag, ":stall"},  32'(m_stall), 32'(e_stall));
        check({tag, ":rd0"},    m_dr[0], s_dr);
        check({tag, ":rd3"},    m_dr[N-1], s_dr);
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            m_sel[i] = 4'($urandom_range(0, 15));
            m_adr[i] = $urandom;
            m_dat[i] = $urandom;
            m_we[i]  = 1'($urandom_range(0, 1));
        end
        s_dr = $urandom;
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // settled outputs, advances the model across the rising edge.
    task automatic step(input string tag, output logic pre_cyc,
                        output logic [N-1:0] pre_ack, output logic [N-1:0] post_gnt);
        int nxt;
        #1;
        pre_cyc = o_cyc;
        pre_ack = m_ack;
        check_model(tag);
        if (mdl_owner >= 0 && m_cyc[mdl_owner]) nxt = mdl_owner;
        else nxt = pick(m_cyc, mdl_owner);
        @(posedge clk);
        #1;
        mdl_owner = nxt;
        if (nxt >= 0) mdl_last = nxt;
        post_gnt = gnt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_stall = 1'b0;
        rand_payload();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        mdl_owner = -1;
        mdl_last  = N - 1;
        #1;
        check_model("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] cyc;
        logic         exp_out_cyc;
        logic [N-1:0] exp_gnt;
    } vec_t;
    vec_t vecs [15];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         pc;
        logic [N-1:0] pa, pg, prev;
        int           gap  [N];
        int           acks [N];
        int           seq  [$];
        int           exp_seq [5];

        vecs[0]  = '{4'b0100, 1'b0, 4'b0100};  // single request, 1-cycle latency
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000};  // release to idle
        vecs[3]  = '{4'b0100, 1'b0, 4'b0100};  // reacquire: grant at t+2
        vecs[4]  = '{4'b0101, 1'b1, 4'b0100};  // no preemption
        vecs[5]  = '{4'b0001, 1'b0, 4'b0001};  // direct handover
        vecs[6]  = '{4'b0001, 1'b1, 4'b0001};
        vecs[7]  = '{4'b0010, 1'b0, 4'b0010};
        vecs[8]  = '{4'b0011, 1'b1, 4'b0010};
        vecs[9]  = '{4'b0001, 1'b0, 4'b0001};
        vecs[10] = '{4'b1001, 1'b1, 4'b0001};
        vecs[11] = '{4'b1000, 1'b0, 4'b1000};
        vecs[12] = '{4'b1110, 1'b1, 4'b1000};
        vecs[13] = '{4'b0110, 1'b0, 4'b0010};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000};

        do_reset();

        // Table-driven sequence.
        for (int i = 0; i < 15; i++) begin
            m_cyc = vecs[i].cyc;
            m_stb = vecs[i].cyc;
            rand_payload();
            step("vec", pc, pa, pg);
            check($sformatf("vec%0d_out_cyc", i), 32'(pc), 32'(vecs[i].exp_out_cyc));
            check($sformatf("vec%0d_gnt", i), 32'(pg), 32'(vecs[i].exp_gnt));
        end

        // Simultaneous request after reset, then handover with one idle cycle.
        do_reset();
        m_cyc = 4'b1010; m_stb = 4'b1010;
        step("simul", pc, pa, pg);
        check("simul_first_gnt", 32'(pg), 32'(4'b0010));
        step("simul", pc, pa, pg);
        check("simul_busy_cyc", 32'(pc), 32'(1));
        m_cyc = 4'b1000; m_stb = 4'b1000;
        step("simul", pc, pa, pg);
        check("simul_gap_cyc", 32'(pc), 32'(0));
        check("simul_second_gnt", 32'(pg), 32'(4'b1000));
        step("simul", pc, pa, pg);
        check("simul_resume_cyc", 32'(pc), 32'(1));

        // No preemption while the owner is stalled downstream.
        do_reset();
        m_cyc = 4'b1000; m_stb = 4'b1000;
        step("nopre", pc, pa, pg);
        check("nopre_gnt0", 32'(pg), 32'(4'b1000));
        for (int k = 0; k < 5; k++) begin
            m_cyc = 4'b1001; m_stb = 4'b1001;
            s_stall = 1'b1; s_ack = 1'b1;
            step("nopre", pc, pa, pg);
            check("nopre_gnt", 32'(pg), 32'(4'b1000));
            check("nopre_ack0", 32'(pa[0]), 32'(0));
            check("nopre_stall0", 32'(m_stall[0]), 32'(1));
        end

        // Asynchronous reset mid-cycle with an ack pending.
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010; s_ack = 1'b1;
        step("mrst", pc, pa, pg);
        #1;
        check("mrst_ack_pending", 32'(m_ack[1]), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_cyc", 32'(o_cyc), 32'(0));
        check("mrst_gnt", 32'(gnt), 32'(0));
        check("mrst_ack", 32'(m_ack), 32'(0));
        check("mrst_owner", 32'(owner), 32'(N - 1));
        mdl_owner = -1; mdl_last = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
        step("mrst", pc, pa, pg);
        check("mrst_regrant_pre", 32'(pc), 32'(0));
        check("mrst_regrant", 32'(pg), 32'(4'b0010));

        // Fairness: everyone requests; each owner releases after two acks.
`ifdef WB_ARB_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 1, 0, 1, 0};
`endif
        do_reset();
        s_ack = 1'b1; s_stall = 1'b0;
        for (int i = 0; i < N; i++) begin gap[i] = 0; acks[i] = 0; end
        prev = '0;
        for (int c = 0; c < 200 && seq.size() < 5; c++) begin
            for (int i = 0; i < N; i++) begin
                m_cyc[i] = (gap[i] == 0);
                if (gap[i] > 0) gap[i]--;
            end
            m_stb = m_cyc;
            step("fair", pc, pa, pg);
            for (int i = 0; i < N; i++) begin
                if (pa[i] && m_cyc[i]) begin
                    acks[i]++;
                    if (acks[i] == 2) begin acks[i] = 0; gap[i] = 1; end
                end
            end
            if (pg != '0 && pg != prev) seq.push_back(oh_idx(pg));
            prev = pg;
        end
        check("fair_count", 32'(seq.size()), 32'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < seq.size()) check($sformatf("fair_order%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(0, 5) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc[i] = 1'b1;
                end
            end
            m_stb   = m_cyc & N'($urandom);
            s_ack   = 1'($urandom_range(0, 1));
            s_stall = 1'($urandom_range(0, 1));
            rand_payload();
            step("rand", pc, pa, pg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
